// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: cache per-word handshake to single-port synchronous SRAM.
// Writes are posted into a small FIFO and drained ahead of any read, so a read
// always observes every write accepted before it. SRAM read data is held by the
// SRAM after the strobe and sampled once the configured wait states elapse.
// Optional feature macro: CACHE_MEM_BRIDGE_PERF_EN adds saturating
// write/read/stall performance counters.
module cache_mem_bridge #(
   parameter int TOTAL_ADDR_W = 18,
   parameter int WBUF_DEPTH   = 4,
   parameter int WAIT_CYCLES  = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [TOTAL_ADDR_W-1:0] i_ADDR,
   input  logic [31:0]             i_WDATA,
   input  logic [3:0]              i_BMASK,
   input  logic                    i_WREN,
   input  logic                    i_VALID,
   output logic                    o_READY,
   output logic [31:0]             o_RDATA,
   output logic                    o_sram_EN,
   output logic                    o_sram_WE,
   output logic [TOTAL_ADDR_W-3:0] o_sram_ADDR,
   output logic [31:0]             o_sram_WDATA,
   output logic [3:0]              o_sram_BMASK,
   input  logic [31:0]             i_sram_RDATA,
   output logic                    o_wbuf_empty
`ifdef CACHE_MEM_BRIDGE_PERF_EN
   ,
   output logic [31:0]             o_perf_wr_cnt,
   output logic [31:0]             o_perf_rd_cnt,
   output logic [31:0]             o_perf_stall_cnt
`endif
);

   localparam int AW = TOTAL_ADDR_W - 2;
   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int WW = $clog2(WAIT_CYCLES + 2);

   typedef enum logic [1:0] {IDLE, WR_BUSY, RD_WAIT, RD_RESP} state_t;

   state_t          state, state_nx;
   logic [AW-1:0]   fifo_addr [WBUF_DEPTH];
   logic [31:0]     fifo_data [WBUF_DEPTH];
   logic [3:0]      fifo_mask [WBUF_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;
   logic [WW-1:0]   wait_cnt, wait_nx;
   logic [31:0]     rdata_q;
   logic            full, empty, push, pop, capture, rd_ready, sram_en;
   logic            unused_addr_lsb;

   assign unused_addr_lsb = ^i_ADDR[1:0];

   assign full  = (count == (PW+1)'(WBUF_DEPTH));
   assign empty = (count == '0);
   // A full FIFO refuses the write even if a pop frees a slot this cycle.
   assign push  = i_VALID & i_WREN & ~full;

   // Reset gates the combinational handshake/strobe so outputs read idle during reset.
   assign o_READY      = ~i_rst & (push | rd_ready);
   assign o_sram_EN    = ~i_rst & sram_en;
   assign o_RDATA      = rdata_q;
   assign o_wbuf_empty = empty & (state == IDLE);

   // Write-buffer storage; contents need no reset since the pointers are cleared.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= i_ADDR[TOTAL_ADDR_W-1:2];
         fifo_data[wr_ptr] <= i_WDATA;
         fifo_mask[wr_ptr] <= i_BMASK;
      end
   end

   // Write-buffer pointers and occupancy.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);
      end
   end

   // State, wait-state counter and read data register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         rdata_q  <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         if (capture) rdata_q <= i_sram_RDATA;
      end
   end

   // Next-state and SRAM command: drain buffered writes before starting a read.
   always_comb begin
      state_nx     = state;
      wait_nx      = wait_cnt;
      pop          = 1'b0;
      capture      = 1'b0;
      rd_ready     = 1'b0;
      sram_en      = 1'b0;
      o_sram_WE    = 1'b0;
      o_sram_ADDR  = fifo_addr[rd_ptr];
      o_sram_WDATA = fifo_data[rd_ptr];
      o_sram_BMASK = fifo_mask[rd_ptr];
      case (state)
         IDLE: begin
            if (!empty) begin
               sram_en   = 1'b1;
               o_sram_WE = 1'b1;
               pop       = 1'b1;
               if (WAIT_CYCLES > 0) begin
                  wait_nx  = WW'(WAIT_CYCLES);
                  state_nx = WR_BUSY;
               end
            end else if (i_VALID && !i_WREN) begin
               sram_en      = 1'b1;
               o_sram_ADDR  = i_ADDR[TOTAL_ADDR_W-1:2];
               o_sram_BMASK = '0;
               wait_nx      = WW'(WAIT_CYCLES);
               state_nx     = RD_WAIT;
            end
         end
         WR_BUSY: begin
            wait_nx = wait_cnt - WW'(1);
            if (wait_cnt == WW'(1)) state_nx = IDLE;
         end
         RD_WAIT: begin
            if (wait_cnt == '0) begin
               capture  = 1'b1;
               state_nx = RD_RESP;
            end else begin
               wait_nx = wait_cnt - WW'(1);
            end
         end
         RD_RESP: begin
            rd_ready = i_VALID & ~i_WREN;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef CACHE_MEM_BRIDGE_PERF_EN
   // Saturating counters: accepted writes, completed reads, stalled request cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_perf_wr_cnt    <= '0;
         o_perf_rd_cnt    <= '0;
         o_perf_stall_cnt <= '0;
      end else begin
         if (push && !(&o_perf_wr_cnt))    o_perf_wr_cnt <= o_perf_wr_cnt + 32'd1;
         if (rd_ready && !(&o_perf_rd_cnt)) o_perf_rd_cnt <= o_perf_rd_cnt + 32'd1;
         if (i_VALID && !o_READY && !(&o_perf_stall_cnt))
            o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb_cache_mem_bridge: directed bench for cache_mem_bridge. Three instances with
// WAIT_CYCLES = 1, 0 and 3 share the request fields; each has a private valid
// and its own behavioural SRAM that logs strobes.
module tb_cache_mem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  vld;
   logic [17:0] addr;
   logic [31:0] wdata;
   logic [3:0]  bmask;
   logic        wren;

   logic [2:0]  rdy, sen, swe, wbe;
   logic [31:0] rdata  [3];
   logic [15:0] saddr  [3];
   logic [31:0] swdata [3];
   logic [3:0]  smask  [3];
`ifdef CACHE_MEM_BRIDGE_PERF_EN
   logic [31:0] pwr [3];
   logic [31:0] prd [3];
   logic [31:0] pst [3];
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      logic [31:0] mem [0:65535];
      logic [31:0] q;
      logic [31:0] wtmp;
      logic [15:0] rd_addr;
      logic [15:0] wlog [$];
      int          n_rd = 0;
      int          n_wr = 0;
      int          wr_at_rd = 0;

      cache_mem_bridge #(.TOTAL_ADDR_W(18), .WBUF_DEPTH(4), .WAIT_CYCLES(WC)) dut (
         .i_clk        (clk),
         .i_rst        (rst),
         .i_ADDR       (addr),
         .i_WDATA      (wdata),
         .i_BMASK      (bmask),
         .i_WREN       (wren),
         .i_VALID      (vld[g]),
         .o_READY      (rdy[g]),
         .o_RDATA      (rdata[g]),
         .o_sram_EN    (sen[g]),
         .o_sram_WE    (swe[g]),
         .o_sram_ADDR  (saddr[g]),
         .o_sram_WDATA (swdata[g]),
         .o_sram_BMASK (smask[g]),
         .i_sram_RDATA (q),
         .o_wbuf_empty (wbe[g])
`ifdef CACHE_MEM_BRIDGE_PERF_EN
         ,
         .o_perf_wr_cnt    (pwr[g]),
         .o_perf_rd_cnt    (prd[g]),
         .o_perf_stall_cnt (pst[g])
`endif
      );

      // SRAM model: 1-cycle read latency, output held until the next read strobe.
      always @(posedge clk) begin
         if (rst) begin
            mem[16] <= 32'hDEADBEEF;
         end else if (sen[g]) begin
            if (swe[g]) begin
               wtmp = mem[saddr[g]];
               for (int b = 0; b < 4; b++)
                  if (smask[g][b]) wtmp[8*b +: 8] = swdata[g][8*b +: 8];
               mem[saddr[g]] <= wtmp;
               n_wr <= n_wr + 1;
               wlog.push_back(saddr[g]);
            end else begin
               q        <= mem[saddr[g]];
               n_rd     <= n_rd + 1;
               rd_addr  <= saddr[g];
               wr_at_rd <= n_wr;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one request to instance g and returns the stalled cycles before
   // acceptance (99 if never accepted) and o_RDATA at the accept point.
   task automatic xfer(input int g, input logic w, input logic [17:0] a,
                       input logic [31:0] d, input logic [3:0] m,
                       output int cyc, output logic [31:0] rd);
      vld    = '0;
      vld[g] = 1'b1;
      wren   = w;
      addr   = a;
      wdata  = d;
      bmask  = m;
      cyc    = 0;
      #1;
      while (!rdy[g] && cyc < 40) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      rd = rdata[g];
      if (!rdy[g]) cyc = 99;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          c, sum, nr0, nw0;
      logic [31:0] r;

      rst = 1'b1; vld = '0; addr = '0; wdata = '0; bmask = '0; wren = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_ready", 32'(rdy), 32'h0);
      chk("rst_en", 32'(sen), 32'h0);
      chk("rst_rdata", rdata[0], 32'h0);
      chk("rst_wbuf_empty", 32'(wbe), 32'h7);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single read, WAIT_CYCLES=1: ready 3 cycles after valid.
      nr0 = gi[0].n_rd; nw0 = gi[0].n_wr;
      xfer(0, 1'b0, 18'h00040, 32'h0, 4'h0, c, r);
      vld = '0;
      chk("rd_latency_w1", 32'(c), 32'd3);
      chk("rd_data", r, 32'hDEADBEEF);
      chk("rd_strobes", 32'(gi[0].n_rd - nr0), 32'd1);
      chk("rd_strobe_addr", 32'(gi[0].rd_addr), 32'h10);
      chk("rd_no_write", 32'(gi[0].n_wr - nw0), 32'd0);

      // Four masked writes then a read: the read waits for all four.
      nw0 = gi[0].n_wr;
      for (int i = 0; i < 4; i++)
         xfer(0, 1'b1, 18'h00100 + 18'(4*i), 32'hA0B0C0D0 | 32'(i), 4'b0101, c, r);
      xfer(0, 1'b0, 18'h00104, 32'h0, 4'h0, c, r);
      vld = '0;
      chk("rd_after_wr_strobe_order", 32'(gi[0].wr_at_rd - nw0), 32'd4);
      chk("rd_after_wr_data", r & 32'h00FF00FF, 32'h00B000D1);

      // Cache line of 16 writes, WAIT_CYCLES=0.
      sum = 0;
      for (int i = 0; i < 16; i++) begin
         xfer(1, 1'b1, 18'h00200 + 18'(4*i), 32'h5000 + 32'(i), 4'hF, c, r);
         if (i < 4) sum += c;
      end
      vld = '0;
      chk("line_first4_stall", 32'(sum), 32'd0);
      for (int k = 0; k < 4; k++) @(negedge clk);
      #1;
      chk("line_wbuf_empty", 32'(wbe[1]), 32'h1);
      chk("line_wr_count", 32'(gi[1].wlog.size()), 32'd16);
      for (int i = 0; i < 16; i++)
         chk("line_wr_order", 32'(gi[1].wlog[i]), 32'h80 + 32'(i));
      chk("line_last_word", gi[1].mem[16'h8F], 32'h500F);

      // FIFO full, WAIT_CYCLES=3: writes 0..4 accepted at once, write 5 stalls 1 cycle.
      sum = 0;
      for (int i = 0; i < 6; i++) begin
         xfer(2, 1'b1, 18'h00300 + 18'(4*i), 32'h6000 + 32'(i), 4'hF, c, r);
         if (i < 5) sum += c;
         else chk("full_stall", 32'(c), 32'd1);
      end
      vld = '0;
      chk("prefull_stall", 32'(sum), 32'd0);
      for (int k = 0; k < 60 && !wbe[2]; k++) @(negedge clk);
      #1;
      chk("full_drained", 32'(wbe[2]), 32'h1);
      chk("full_wr_count", 32'(gi[2].wlog.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         chk("full_wr_order", 32'(gi[2].wlog[i]), 32'hC0 + 32'(i));
      chk("full_last_word", gi[2].mem[16'hC5], 32'h6005);

      // Read on WAIT_CYCLES=3 (latency 5), then reset mid RD_WAIT with 2 writes buffered.
      xfer(2, 1'b0, 18'h00300, 32'h0, 4'h0, c, r);
      chk("rd_latency_w3", 32'(c), 32'd5);
      chk("rd_data_w3", r, 32'h6000);
      nr0 = gi[2].n_rd; nw0 = gi[2].n_wr;
      @(negedge clk);
      wren = 1'b1; addr = 18'h00400; wdata = 32'h7000; bmask = 4'hF;
      @(negedge clk);
      addr = 18'h00404; wdata = 32'h7001;
      @(negedge clk);
      wren = 1'b0; addr = 18'h00300;
      #1;
      chk("rdwait_wbuf_busy", 32'(wbe[2]), 32'h0);
      chk("rdwait_rd_strobe", 32'(gi[2].n_rd - nr0), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_ready", 32'(rdy[2]), 32'h0);
      chk("async_rst_en", 32'(sen[2]), 32'h0);
      chk("async_rst_we", 32'(swe[2]), 32'h0);
      chk("async_rst_rdata", rdata[2], 32'h0);
      chk("async_rst_wbuf_empty", 32'(wbe[2]), 32'h1);
      vld = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) @(negedge clk);
      #1;
      chk("post_rst_no_rd", 32'(gi[2].n_rd - nr0), 32'd1);
      chk("post_rst_no_wr", 32'(gi[2].n_wr - nw0), 32'd0);
      chk("post_rst_wbuf_empty", 32'(wbe[2]), 32'h1);
      @(negedge clk);

`ifdef CACHE_MEM_BRIDGE_PERF_EN
      // Counters were cleared by the reset above; 3 writes + 2 reads, WAIT_CYCLES=0.
      sum = 0;
      for (int i = 0; i < 3; i++) begin
         xfer(1, 1'b1, 18'h00500 + 18'(4*i), 32'h9000 + 32'(i), 4'hF, c, r);
         sum += c;
      end
      for (int i = 0; i < 2; i++) begin
         xfer(1, 1'b0, 18'h00500, 32'h0, 4'h0, c, r);
         sum += c;
      end
      vld = '0;
      @(negedge clk);
      #1;
      chk("perf_bench_stalls", 32'(sum), 32'd5);
      chk("perf_wr_cnt", pwr[1], 32'd3);
      chk("perf_rd_cnt", prd[1], 32'd2);
      chk("perf_stall_cnt", pst[1], 32'(sum));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
